ssp_rx: RTL and testbench

Receive half of the serial synchronous port. It deserialises 8-bit frames from the SSP serial lines (SSPCLKIN, SSPFSSIN, SSPRXD) into a 4-entry receive FIFO. The FIFO is read over the APB-style PSEL/PWRITE/PRDATA port. In loopback it is the consumer of the transmit path's SSPCLKOUT/SSPFSSOUT/SSPTXD.

---
 rtl/ssp_pkg.sv | 15 +
 rtl/ssp_fifo.sv | 67 ++++++
 rtl/ssp_rx.sv | 113 +++++++++++
 tb/tb_ssp_rx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_pkg.sv
// ssp_pkg: definitions shared by the SSP receive and transmit paths.
//   SSP_DATA_W     - serial frame / FIFO word width
//   SSP_FIFO_DEPTH - entries in each SSP FIFO (power of two)
//   rx_state_t     - receive deserialiser states
package ssp_pkg;

    localparam int SSP_DATA_W     = 8;
    localparam int SSP_FIFO_DEPTH = 4;

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/ssp_fifo.sv
// ssp_fifo: DEPTH x DATA_W synchronous FIFO with show-ahead output.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst   - asynchronous active-high reset (clears pointers, count, storage)
//   i_push  - write i_din; accepted when not full, or when a pop happens too
//   i_pop   - advance read pointer; ignored when empty
//   i_din   - write data
//   o_dout  - word at the read pointer (stale contents when empty)
//   o_full  - count == DEPTH
//   o_empty - count == 0
module ssp_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == (AW + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ssp_rx.sv
// ssp_rx: receive half of the serial synchronous port.
// Deserialises MSB-first frames (one-period FSS pulse ahead of the MSB) into a
// receive FIFO that is read over the APB-style select/read port.
// Ports:
//   PCLK      - sole clock, rising edge
//   CLEAR     - asynchronous active-high reset
//   PSEL      - peripheral select
//   PWRITE    - 1 = write (ignored), 0 = read; a read pops one word per cycle
//   SSPCLKIN  - serial clock, synchronous to PCLK, at most PCLK/2
//   SSPFSSIN  - frame sync
//   SSPRXD    - serial data
//   PRDATA    - head-of-FIFO word (show-ahead)
//   SSPRXINTR - high while the FIFO is full
module ssp_rx
    import ssp_pkg::*;
#(
    parameter int DATA_W = SSP_DATA_W,
    parameter int DEPTH  = SSP_FIFO_DEPTH
) (
    input  logic              PCLK,
    input  logic              CLEAR,
    input  logic              PSEL,
    input  logic              PWRITE,
    input  logic              SSPCLKIN,
    input  logic              SSPFSSIN,
    input  logic              SSPRXD,
    output logic [DATA_W-1:0] PRDATA,
    output logic              SSPRXINTR
);

    localparam int BCW = $clog2(DATA_W);

    rx_state_t         r_state;
    rx_state_t         w_state_nxt;
    logic [BCW-1:0]    r_bitcnt;
    logic [BCW-1:0]    w_bitcnt_nxt;
    logic [DATA_W-1:0] r_shreg;
    logic [DATA_W-1:0] w_shreg_nxt;
    logic              r_sclk_q;

    logic w_sample;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // Sample on the falling edge of SSPCLKIN as seen in the PCLK domain.
    assign w_sample = r_sclk_q && !SSPCLKIN;
    assign w_pop    = PSEL && !PWRITE && !w_empty;

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state  <= RX_IDLE;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_sclk_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_sclk_q <= SSPCLKIN;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_push       = 1'b0;
        if (w_sample) begin
            case (r_state)
                RX_IDLE: begin
                    if (SSPFSSIN) begin
                        w_state_nxt  = RX_SHIFT;
                        w_bitcnt_nxt = '0;
                    end
                end
                RX_SHIFT: begin
                    w_shreg_nxt = {r_shreg[DATA_W-2:0], SSPRXD};
                    if (r_bitcnt == BCW'(DATA_W - 1)) begin
                        w_push       = 1'b1;
                        w_bitcnt_nxt = '0;
                        // FSS on the last bit chains straight into the next frame.
                        if (!SSPFSSIN) begin
                            w_state_nxt = RX_IDLE;
                        end
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + BCW'(1);
                    end
                end
                default: w_state_nxt = RX_IDLE;
            endcase
        end
    end

    // The completed byte is the shift register including this sample's bit.
    ssp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .i_clk   (PCLK),
        .i_rst   (CLEAR),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_shreg_nxt),
        .o_dout  (PRDATA),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign SSPRXINTR = w_full;

endmodule

// File: tb/tb_ssp_rx.sv
// tb_ssp_rx: scoreboard bench for ssp_rx. Frames are driven at SSPCLKIN =
// PCLK/2; a byte-level FIFO model predicts PRDATA/SSPRXINTR, read cycles queue
// their expected word, and a monitor compares on the read cycle.
module tb_ssp_rx;

    localparam int DEPTH = 4;

    logic       PCLK = 1'b0;
    logic       CLEAR;
    logic       PSEL;
    logic       PWRITE;
    logic       SSPCLKIN;
    logic       SSPFSSIN;
    logic       SSPRXD;
    logic [7:0] PRDATA;
    logic       SSPRXINTR;

    typedef struct packed {
        bit         valid;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    exp_q[$];
    logic [7:0] model_q[$];
    int         total = 0;
    int         bad   = 0;

    ssp_rx #(.DATA_W(8), .DEPTH(DEPTH)) dut (
        .PCLK      (PCLK),
        .CLEAR     (CLEAR),
        .PSEL      (PSEL),
        .PWRITE    (PWRITE),
        .SSPCLKIN  (SSPCLKIN),
        .SSPFSSIN  (SSPFSSIN),
        .SSPRXD    (SSPRXD),
        .PRDATA    (PRDATA),
        .SSPRXINTR (SSPRXINTR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 ns after a rising edge, well clear of both edges.
    task automatic cyc();
        @(posedge PCLK);
        #2;
    endtask

    // Byte-level FIFO behaviour for one PCLK edge.
    task automatic model_edge(input bit rd, input bit push, input logic [7:0] b);
        bit pop;
        bit acc;
        pop = rd && (model_q.size() != 0);
        acc = push && ((model_q.size() < DEPTH) || pop);
        if (pop) void'(model_q.pop_front());
        if (acc) model_q.push_back(b);
    endtask

    task automatic chk_state(input string tag);
        check1({tag, "_intr"}, SSPRXINTR, model_q.size() == DEPTH);
        if (model_q.size() != 0) check8({tag, "_head"}, PRDATA, model_q[0]);
    endtask

    function automatic rd_exp_t mk_exp();
        rd_exp_t r;
        r.valid = (model_q.size() != 0);
        r.data  = r.valid ? model_q[0] : 8'h00;
        return r;
    endfunction

    // One SSPCLKIN period: high for a PCLK cycle, then low; sampled at the fall.
    task automatic do_bit(input bit fss, input bit d, input bit rd, input bit push,
                          input logic [7:0] b);
        SSPCLKIN = 1'b1;
        SSPFSSIN = fss;
        SSPRXD   = d;
        PSEL     = 1'b0;
        PWRITE   = 1'b0;
        cyc();
        chk_state("hi");
        SSPCLKIN = 1'b0;
        if (rd) begin
            PSEL = 1'b1;
            exp_q.push_back(mk_exp());
        end
        cyc();
        PSEL = 1'b0;
        model_edge(rd, push, b);
        chk_state("lo");
    endtask

    // Mid-frame FSS values are random: the receiver must ignore them.
    task automatic send_frame(input logic [7:0] b, input bit lead, input bit fss_last,
                              input bit rd_last);
        if (lead) do_bit(1'b1, 1'($urandom), 1'b0, 1'b0, 8'h00);
        for (int i = 7; i >= 0; i--) begin
            do_bit((i == 0) ? fss_last : 1'($urandom), b[i], (i == 0) && rd_last,
                   i == 0, b);
        end
    endtask

    task automatic read_word();
        SSPCLKIN = 1'b0;
        PSEL     = 1'b1;
        PWRITE   = 1'b0;
        exp_q.push_back(mk_exp());
        cyc();
        PSEL = 1'b0;
        model_edge(1'b1, 1'b0, 8'h00);
        chk_state("rd");
    endtask

    task automatic write_cycle();
        SSPCLKIN = 1'b0;
        PSEL     = 1'b1;
        PWRITE   = 1'b1;
        cyc();
        PSEL   = 1'b0;
        PWRITE = 1'b0;
        chk_state("wr");
    endtask

    // Monitor: a read cycle consumes one scoreboard entry.
    always @(negedge PCLK) begin
        rd_exp_t r;
        if (CLEAR === 1'b0 && PSEL === 1'b1 && PWRITE === 1'b0) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow: read seen, none expected at %0t", $time);
            end else begin
                r = exp_q.pop_front();
                if (r.valid) check8("rd_data", PRDATA, r.data);
                else         check1("rd_empty_intr", SSPRXINTR, 1'b0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        bit chained;
        bit bb;
        int k;
        logic [7:0] fill [5];

        CLEAR    = 1'b1;
        PSEL     = 1'b0;
        PWRITE   = 1'b0;
        SSPCLKIN = 1'b0;
        SSPFSSIN = 1'b0;
        SSPRXD   = 1'b0;
        repeat (3) cyc();
        check8("reset_prdata", PRDATA, 8'h00);
        check1("reset_intr", SSPRXINTR, 1'b0);
        CLEAR = 1'b0;
        cyc();

        // Single frame
        send_frame(8'h94, 1'b1, 1'b0, 1'b0);
        check8("single", PRDATA, 8'h94);
        read_word();

        // Fill and overrun
        fill = '{8'h0F, 8'h51, 8'h24, 8'h67, 8'hF3};
        foreach (fill[i]) begin
            do_bit(1'b0, 1'($urandom), 1'b0, 1'b0, 8'h00);
            send_frame(fill[i], 1'b1, 1'b0, 1'b0);
        end
        check1("full_intr", SSPRXINTR, 1'b1);
        repeat (4) read_word();

        // Back-to-back frames
        send_frame(8'hB6, 1'b1, 1'b1, 1'b0);
        send_frame(8'h84, 1'b0, 1'b0, 1'b0);
        check8("b2b_first", PRDATA, 8'hB6);
        repeat (2) read_word();

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        check1("pushpop_full", SSPRXINTR, 1'b1);
        repeat (4) read_word();

        // Empty read, then a new frame
        repeat (2) read_word();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check8("after_empty", PRDATA, 8'hA5);
        read_word();

        // Randomized traffic
        chained = 1'b0;
        repeat (60) begin
            k = chained ? 0 : $urandom_range(0, 4);
            case (k)
                0, 1: begin
                    bb = ($urandom_range(0, 3) == 0);
                    send_frame(8'($urandom), !chained, bb, $urandom_range(0, 2) == 0);
                    chained = bb;
                end
                2:       read_word();
                3:       write_cycle();
                default: do_bit(1'b0, 1'($urandom), 1'b0, 1'b0, 8'h00);
            endcase
        end
        if (chained) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        while (model_q.size() != 0) read_word();

        // Reset mid-frame
        send_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        do_bit(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (5) do_bit(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        SSPCLKIN = 1'b1;
        CLEAR    = 1'b1;
        #1;
        check8("midrst_prdata", PRDATA, 8'h00);
        check1("midrst_intr", SSPRXINTR, 1'b0);
        model_q.delete();
        cyc();
        SSPCLKIN = 1'b0;
        CLEAR    = 1'b0;
        cyc();
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check8("post_rst", PRDATA, 8'h5A);
        read_word();

        repeat (3) cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
